// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch front end. Chooses the next PC, issues requests to
//   instruction memory and loads the IF/ID pipeline register with the
//   fetched word and its PC+4. ID stalls and EX redirects are handled here.
//
//   Ports
//     clock        system clock, rising-edge active
//     reset        synchronous, active-high reset
//     pc_cur       current PC from the pc register
//     pc_next      next PC to the pc register (combinational)
//     imem_req     fetch request, held until imem_valid
//     imem_addr    fetch address, stable while imem_req is high
//     imem_valid   response valid for the current request (may be same cycle)
//     imem_rdata   instruction word, qualified by imem_valid
//     stall        ID hazard: hold IF/ID and do not advance the PC
//     redirect     EX branch taken / jump: flush and load redirect_pc
//     redirect_pc  redirect target (low two bits ignored)
//     ifid_valid   IF/ID holds a valid instruction
//     ifid_instr   IF/ID instruction word
//     ifid_pc4     IF/ID PC+4 of that instruction
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Side buffer for a word that arrived while ID was stalled.
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;
  logic [31:0] hold_instr_next;
  logic [31:0] hold_pc4_next;

  // Address of a request abandoned by a redirect; re-presented until the
  // memory answers it so the request/response pairing stays intact.
  logic [31:0] addr_q;
  logic [31:0] addr_q_next;

  logic        ifid_valid_next;
  logic [31:0] ifid_instr_next;
  logic [31:0] ifid_pc4_next;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;

  assign pc_plus4        = pc_cur + 32'd4;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_next      = state;
    pc_next         = pc_cur;
    imem_req        = 1'b0;
    imem_addr       = pc_cur;
    ifid_valid_next = ifid_valid;
    ifid_instr_next = ifid_instr;
    ifid_pc4_next   = ifid_pc4;
    hold_instr_next = hold_instr;
    hold_pc4_next   = hold_pc4;
    addr_q_next     = addr_q;

    case (state)
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_cur;
        if (redirect) begin
          pc_next         = redirect_target;
          ifid_valid_next = 1'b0;
          // An outstanding request must still be drained before the
          // memory can accept the new target.
          if (!imem_valid) begin
            addr_q_next = pc_cur;
            state_next  = DRAIN;
          end else begin
            state_next  = FETCH;
          end
        end else if (imem_valid && !stall) begin
          ifid_valid_next = 1'b1;
          ifid_instr_next = imem_rdata;
          ifid_pc4_next   = pc_plus4;
          pc_next         = pc_plus4;
        end else if (imem_valid && stall) begin
          hold_instr_next = imem_rdata;
          hold_pc4_next   = pc_plus4;
          state_next      = HELD;
        end else if (!stall) begin
          ifid_valid_next = 1'b0;
        end
      end

      HELD: begin
        imem_req = 1'b0;
        if (redirect) begin
          pc_next         = redirect_target;
          ifid_valid_next = 1'b0;
          state_next      = FETCH;
        end else if (!stall) begin
          ifid_valid_next = 1'b1;
          ifid_instr_next = hold_instr;
          ifid_pc4_next   = hold_pc4;
          pc_next         = pc_plus4;
          state_next      = FETCH;
        end
      end

      DRAIN: begin
        imem_req        = 1'b1;
        imem_addr       = addr_q;
        ifid_valid_next = 1'b0;
        // A second redirect only retargets the PC; the abandoned request
        // is still outstanding, so keep draining it until it answers.
        if (redirect) begin
          pc_next = redirect_target;
        end
        if (imem_valid) begin
          state_next = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase

    if (reset) begin
      pc_next  = RESET_PC;
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FETCH;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
      hold_instr <= 32'd0;
      hold_pc4   <= 32'd0;
      addr_q     <= 32'd0;
    end else begin
      state      <= state_next;
      ifid_valid <= ifid_valid_next;
      ifid_instr <= ifid_instr_next;
      ifid_pc4   <= ifid_pc4_next;
      hold_instr <= hold_instr_next;
      hold_pc4   <= hold_pc4_next;
      addr_q     <= addr_q_next;
    end
  end

endmodule
